data_mem_ctrl: RTL and testbench

Sequencing controller between the MEM stage and a single-port, word-wide, synchronous-read data RAM. It performs sub-word (byte/halfword) stores as read-modify-write, aligns and zero-extends sub-word loads, and stalls the pipeline while an access is incomplete. It also shares the RAM with the debug unit's read port at lower priority than the pipeline.

---
 rtl/data_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Sequences MEM-stage loads/stores onto a single-port synchronous-read RAM (RMW for sub-word stores).
// Shares the RAM with a low-priority debug read port; stalls the pipeline for the first cycle of multi-cycle accesses.
module data_mem_ctrl #(
  parameter int NB_ADDR    = 32,
  parameter int NB_DATA    = 32,
  parameter int RAM_ADDR_W = 10
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_MEM_mem_read,
  input  logic                  i_MEM_mem_write,
  input  logic                  i_MEM_word_enable,
  input  logic                  i_MEM_halfword_enable,
  input  logic                  i_MEM_byte_enable,
  input  logic [NB_ADDR-1:0]    i_MEM_alu_result,
  input  logic [NB_DATA-1:0]    i_MEM_write_data,
  output logic [NB_DATA-1:0]    o_MEM_mem_data,
  output logic                  o_mem_stall,
  input  logic                  i_du_req,
  input  logic [RAM_ADDR_W-1:0] i_du_addr,
  output logic [NB_DATA-1:0]    o_du_data,
  output logic                  o_du_valid,
  output logic [RAM_ADDR_W-1:0] o_ram_addr,
  output logic                  o_ram_we,
  output logic [NB_DATA-1:0]    o_ram_wdata,
  input  logic [NB_DATA-1:0]    i_ram_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW, DU_READ} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t                state;
  size_t                 size_d, size_q;
  logic [RAM_ADDR_W-1:0] word_addr, addr_q;
  logic [1:0]            lane_q;
  logic [15:0]           wdata_q;
  logic [NB_DATA-1:0]    hold, load_val, merged;
  logic                  req, du_accept;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{i_MEM_alu_result[NB_ADDR-1:RAM_ADDR_W+2]};

  assign req       = i_MEM_mem_read | i_MEM_mem_write;
  assign word_addr = i_MEM_alu_result[RAM_ADDR_W+1:2];
  assign du_accept = !req && i_du_req && !o_du_valid;

  always_comb begin
    size_d = SZ_WORD;
    if (i_MEM_word_enable)          size_d = SZ_WORD;
    else if (i_MEM_halfword_enable) size_d = SZ_HALF;
    else if (i_MEM_byte_enable)     size_d = SZ_BYTE;
  end

  // Lane extraction and merge both work from the registered lane/size.
  always_comb begin
    load_val = i_ram_rdata;
    merged   = i_ram_rdata;
    case (size_q)
      SZ_HALF: begin
        load_val = {{(NB_DATA-16){1'b0}}, i_ram_rdata[{lane_q[1], 4'b0000} +: 16]};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
      SZ_BYTE: begin
        load_val = {{(NB_DATA-8){1'b0}}, i_ram_rdata[{lane_q, 3'b000} +: 8]};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ram_addr     = addr_q;
    o_ram_we       = 1'b0;
    o_ram_wdata    = i_MEM_write_data;
    o_mem_stall    = 1'b0;
    o_MEM_mem_data = hold;
    case (state)
      IDLE: begin
        if (req) begin
          o_ram_addr = word_addr;
          if (i_MEM_mem_write && size_d == SZ_WORD) o_ram_we = 1'b1;
          else                                      o_mem_stall = 1'b1;
        end else if (du_accept) begin
          o_ram_addr = i_du_addr;
        end
      end
      LOAD: o_MEM_mem_data = load_val;
      RMW: begin
        o_ram_we    = 1'b1;
        o_ram_wdata = merged;
      end
      default: ;
    endcase
    // Reset kills any in-flight write or stall immediately, not at the next edge.
    if (!i_reset) begin
      o_ram_we    = 1'b0;
      o_mem_stall = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      size_q     <= SZ_WORD;
      addr_q     <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      hold       <= '0;
      o_du_data  <= '0;
      o_du_valid <= 1'b0;
    end else begin
      o_du_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= word_addr;
            lane_q  <= i_MEM_alu_result[1:0];
            size_q  <= size_d;
            wdata_q <= i_MEM_write_data[15:0];
            if (!i_MEM_mem_write)      state <= LOAD;
            else if (size_d != SZ_WORD) state <= RMW;
          end else if (du_accept) begin
            state <= DU_READ;
          end
        end
        LOAD: begin
          hold  <= load_val;
          state <= IDLE;
        end
        RMW: state <= IDLE;
        DU_READ: begin
          o_du_data  <= i_ram_rdata;
          o_du_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural synchronous RAM and
// queue-based scoreboards for RAM writes, load data and debug reads.
module tb_data_mem_ctrl;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_MEM_mem_read, i_MEM_mem_write;
  logic        i_MEM_word_enable, i_MEM_halfword_enable, i_MEM_byte_enable;
  logic [31:0] i_MEM_alu_result, i_MEM_write_data;
  logic [31:0] o_MEM_mem_data;
  logic        o_mem_stall;
  logic        i_du_req;
  logic [9:0]  i_du_addr;
  logic [31:0] o_du_data;
  logic        o_du_valid;
  logic [9:0]  o_ram_addr;
  logic        o_ram_we;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;

  logic [31:0] mem [0:1023] = '{default: 32'h0};

  logic [41:0] wr_q [$];
  logic [31:0] ld_q [$];
  logic [31:0] du_q [$];

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt = 0;

  always #5 i_clock = ~i_clock;

  data_mem_ctrl dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_MEM_mem_read(i_MEM_mem_read), .i_MEM_mem_write(i_MEM_mem_write),
    .i_MEM_word_enable(i_MEM_word_enable), .i_MEM_halfword_enable(i_MEM_halfword_enable),
    .i_MEM_byte_enable(i_MEM_byte_enable), .i_MEM_alu_result(i_MEM_alu_result),
    .i_MEM_write_data(i_MEM_write_data), .o_MEM_mem_data(o_MEM_mem_data),
    .o_mem_stall(o_mem_stall), .i_du_req(i_du_req), .i_du_addr(i_du_addr),
    .o_du_data(o_du_data), .o_du_valid(o_du_valid), .o_ram_addr(o_ram_addr),
    .o_ram_we(o_ram_we), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  always @(posedge i_clock) begin
    if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
    i_ram_rdata <= mem[o_ram_addr];
  end

  always @(negedge i_clock) if (o_mem_stall) stall_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_req();
    i_MEM_mem_read        = 1'b0;
    i_MEM_mem_write       = 1'b0;
    i_MEM_word_enable     = 1'b0;
    i_MEM_halfword_enable = 1'b0;
    i_MEM_byte_enable     = 1'b0;
    i_MEM_alu_result      = 32'h0;
    i_MEM_write_data      = 32'h0;
  endtask

  // w: 0 byte, 1 halfword, 2 word
  task automatic set_width(input int w);
    i_MEM_word_enable     = (w == 2);
    i_MEM_halfword_enable = (w == 1);
    i_MEM_byte_enable     = (w == 0);
  endtask

  task automatic check_write(input string tag);
    logic [41:0] e;
    if (wr_q.size() == 0) begin
      check({tag, "_wq_empty"}, 32'd1, 32'd0);
    end else begin
      e = wr_q.pop_front();
      check({tag, "_we"},    {31'd0, o_ram_we}, 32'd1);
      check({tag, "_waddr"}, {22'd0, o_ram_addr}, {22'd0, e[41:32]});
      check({tag, "_wdata"}, o_ram_wdata, e[31:0]);
    end
  endtask

  task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input int w, input logic [31:0] exp_word);
    wr_q.push_back({addr[11:2], exp_word});
    i_MEM_mem_write  = 1'b1;
    set_width(w);
    i_MEM_alu_result = addr;
    i_MEM_write_data = data;
    @(negedge i_clock);
    if (w == 2) begin
      check({tag, "_stall"}, {31'd0, o_mem_stall}, 32'd0);
      check_write(tag);
      step();
      clear_req();
    end else begin
      check({tag, "_stall1"}, {31'd0, o_mem_stall}, 32'd1);
      check({tag, "_nowe1"},  {31'd0, o_ram_we}, 32'd0);
      step();
      clear_req();
      i_MEM_alu_result = 32'hFFFF_FFF7;
      i_MEM_write_data = 32'hDEAD_BEEF;
      @(negedge i_clock);
      check({tag, "_stall2"}, {31'd0, o_mem_stall}, 32'd0);
      check_write(tag);
      step();
      clear_req();
    end
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input int w,
                      input logic [31:0] exp);
    logic [31:0] e;
    ld_q.push_back(exp);
    i_MEM_mem_read   = 1'b1;
    set_width(w);
    i_MEM_alu_result = addr;
    @(negedge i_clock);
    check({tag, "_stall1"}, {31'd0, o_mem_stall}, 32'd1);
    check({tag, "_nowe"},   {31'd0, o_ram_we}, 32'd0);
    step();
    clear_req();
    i_MEM_alu_result = 32'hFFFF_FFF7;
    @(negedge i_clock);
    check({tag, "_stall2"}, {31'd0, o_mem_stall}, 32'd0);
    e = ld_q.pop_front();
    check({tag, "_data"}, o_MEM_mem_data, e);
    step();
  endtask

  initial begin
    int s0;
    int lat;
    int pulses;
    logic [31:0] e;

    i_reset   = 1'b0;
    i_du_req  = 1'b0;
    i_du_addr = '0;
    clear_req();
    step();
    step();
    // Request held during reset must not stall or write.
    i_MEM_mem_read = 1'b1;
    #1;
    check("rst_stall",   {31'd0, o_mem_stall}, 32'd0);
    check("rst_we",      {31'd0, o_ram_we}, 32'd0);
    check("rst_du_vld",  {31'd0, o_du_valid}, 32'd0);
    check("rst_memdata", o_MEM_mem_data, 32'h0);
    check("rst_du_data", o_du_data, 32'h0);
    clear_req();
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    // Reset landing in the RMW cycle must drop the write immediately.
    i_MEM_mem_write   = 1'b1;
    i_MEM_byte_enable = 1'b1;
    i_MEM_alu_result  = 32'd8;
    i_MEM_write_data  = 32'h0000_00AA;
    @(negedge i_clock);
    check("rmwrst_stall", {31'd0, o_mem_stall}, 32'd1);
    step();
    clear_req();
    #1;
    check("rmwrst_we_pre", {31'd0, o_ram_we}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("rmwrst_we",    {31'd0, o_ram_we}, 32'd0);
    check("rmwrst_stall0", {31'd0, o_mem_stall}, 32'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    load("ld8_after_rst", 32'd8, 2, 32'h0);

    store("sb10", 32'd10, 32'h0000_000E, 0, 32'h000E_0000);
    load("lh10", 32'd10, 1, 32'h0000_000E);
    load("lb11", 32'd11, 0, 32'h0000_0000);
    check("hold_after_lb11", o_MEM_mem_data, 32'h0);
    store("sw0", 32'd0, 32'd257, 2, 32'h0000_0101);
    load("lb1", 32'd1, 0, 32'h0000_0001);
    store("sh2", 32'd2, 32'h0000_BEEF, 1, 32'hBEEF_0101);

    s0 = stall_cnt;
    load("b2b_w0", 32'd0, 2, 32'hBEEF_0101);
    load("b2b_w2", 32'd8, 2, 32'h000E_0000);
    check("b2b_stalls", stall_cnt - s0, 32'd2);

    // Debug read starved by continuous pipeline loads, then served.
    i_du_req  = 1'b1;
    i_du_addr = 10'd0;
    du_q.push_back(32'hBEEF_0101);
    for (int k = 0; k < 3; k++) begin
      load("du_busy_ld", 32'd0, 2, 32'hBEEF_0101);
      check("du_starved", {31'd0, o_du_valid}, 32'd0);
    end
    lat = 0;
    while (!o_du_valid && lat < 10) begin
      step();
      lat++;
    end
    check("du_latency", lat, 32'd2);
    e = (du_q.size() != 0) ? du_q.pop_front() : 32'hXXXX_XXXX;
    check("du_data", o_du_data, e);
    i_du_req = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_du_valid) pulses++;
    end
    check("du_one_pulse", pulses, 32'd0);

    // Read+write with byte and word enables: a plain word store.
    check("hold_pre_rw", o_MEM_mem_data, 32'hBEEF_0101);
    wr_q.push_back({10'd1, 32'h1234_5678});
    i_MEM_mem_read    = 1'b1;
    i_MEM_mem_write   = 1'b1;
    i_MEM_byte_enable = 1'b1;
    i_MEM_word_enable = 1'b1;
    i_MEM_alu_result  = 32'd4;
    i_MEM_write_data  = 32'h1234_5678;
    @(negedge i_clock);
    check("rw_stall", {31'd0, o_mem_stall}, 32'd0);
    check_write("rw");
    check("rw_memdata", o_MEM_mem_data, 32'hBEEF_0101);
    step();
    clear_req();
    @(negedge i_clock);
    check("rw_idle_we", {31'd0, o_ram_we}, 32'd0);
    check("rw_memdata2", o_MEM_mem_data, 32'hBEEF_0101);
    step();
    load("lw4", 32'd4, 2, 32'h1234_5678);

    check("wr_q_drained", wr_q.size(), 32'd0);
    check("ld_q_drained", ld_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
